// File: rtl/led_fade_pwm.sv
// led_fade_pwm: fades each LED linearly toward its commanded on/off state and renders its brightness level with per-LED PWM.
module led_fade_pwm #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic             enable,
  output logic [WIDTH-1:0] led_out,
  output logic             fade_busy
);
  localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
  localparam int PS_W = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);
  logic [WIDTH-1:0]                r_target;
  logic [WIDTH-1:0][PWM_BITS-1:0]  r_level;
  logic [WIDTH-1:0][PWM_BITS-1:0]  w_level_nxt;
  logic [WIDTH-1:0][PWM_BITS-1:0]  w_goal;
  logic [PS_W-1:0]                 r_presc;
  logic [PWM_BITS-1:0]             r_pwm;
  logic [WIDTH-1:0]                w_led;
  logic                            w_tick;
  logic                            w_busy;
  assign w_tick = r_presc == PS_LAST;
  // levels saturate at both ends; bypass snaps straight to the goal
  always_comb begin
    w_busy      = 1'b0;
    w_goal      = '0;
    w_led       = '0;
    w_level_nxt = r_level;
    for (int i = 0; i < WIDTH; i++) begin
      w_goal[i]      = r_target[i] ? MAX_LEVEL : '0;
      w_led[i]       = r_level[i] == MAX_LEVEL || r_level[i] > r_pwm;
      w_level_nxt[i] = !enable ? w_goal[i] :
                       !w_tick ? r_level[i] :
                       (r_target[i] && r_level[i] != MAX_LEVEL) ? r_level[i] + 1'b1 :
                       (!r_target[i] && r_level[i] != '0) ? r_level[i] - 1'b1 :
                       r_level[i];
      w_busy         = w_busy | (r_level[i] != w_goal[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_target  <= '0;
      r_level   <= '0;
      r_presc   <= '0;
      r_pwm     <= '0;
      led_out   <= '0;
      fade_busy <= 1'b0;
    end else begin
      r_target  <= in_port;
      r_level   <= w_level_nxt;
      r_presc   <= (!enable || w_tick) ? '0 : r_presc + 1'b1;
      r_pwm     <= enable ? r_pwm + 1'b1 : '0;
      led_out   <= enable ? w_led : r_target;
      fade_busy <= w_busy;
    end
  end
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: directed vectors and fade sequences for led_fade_pwm with PWM_BITS=4, STEP_DIV=4.
module tb_led_fade_pwm;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_port;
  logic       enable;
  logic [7:0] led_out;
  logic       fade_busy;
  int         errors = 0;
  int         checks = 0;

  led_fade_pwm #(.WIDTH(8), .PWM_BITS(4), .STEP_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .enable(enable),
    .led_out(led_out), .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic [7:0] led;
    logic       busy;
  } vec_t;

  // outputs expected just after the edge on which the inputs are sampled
  vec_t tbl [15] = '{
    '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0},
    '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0},
    '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0},
    '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0},
    '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1},
    '{1'b1, 1'b0, 8'hA5, 8'hFF, 1'b1},
    '{1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1},
    '{1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0},
    '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0},
    '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0},
    '{1'b0, 1'b0, 8'hA5, 8'h00, 1'b0},
    '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0},
    '{1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1},
    '{1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0},
    '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0}
  };

  // level after edge m of a fade from reset; target drops to 0 after edge rev (rev multiple of 4)
  function automatic int lvl(input int m, input int rev);
    int u, d;
    u = (m / 4 > 15) ? 15 : m / 4;
    d = rev / 4 - (m - rev) / 4;
    if (rev == 0 || m <= rev) return u;
    return (d < 0) ? 0 : d;
  endfunction

  function automatic logic exp_led(input int m, input int rev);
    int l;
    l = lvl(m, rev);
    return l == 15 || l > m % 16;
  endfunction

  function automatic logic exp_busy(input int m, input int rev);
    int g;
    g = (m >= 1 && (rev == 0 || m <= rev)) ? 15 : 0;
    return lvl(m, rev) != g;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] el, input logic eb);
    checks++;
    if (led_out !== el || fade_busy !== eb) begin
      errors++;
      $display("FAIL %s[%0d]: led_out=%h fade_busy=%b, expected led_out=%h fade_busy=%b",
               name, idx, led_out, fade_busy, el, eb);
    end
  endtask

  task automatic rst_cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("reset", i, 8'h00, 1'b0);
    end
  endtask

  task automatic fade_run(input string name, input logic [7:0] pat, input int rev, input int cycles);
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clk);
      if (n == 1) begin
        reset_n = 1'b1;
        in_port = pat;
      end
      if (rev != 0 && n == rev + 1) in_port = 8'h00;
      @(posedge clk); #1;
      chk(name, n, exp_led(n - 1, rev) ? pat : 8'h00, exp_busy(n - 1, rev));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    in_port = 8'hFF;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      reset_n = tbl[i].rst_n;
      enable  = tbl[i].en;
      in_port = tbl[i].din;
      @(posedge clk); #1;
      chk("table", i, tbl[i].led, tbl[i].busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("bypass_exit", i, 8'hA5, 1'b0);
    end
    @(negedge clk);
    in_port = 8'h01;
    rst_cyc(2);
    fade_run("fade_up", 8'h01, 0, 72);
    rst_cyc(1);
    fade_run("reverse", 8'h01, 28, 64);
    rst_cyc(1);
    fade_run("fade_ff", 8'hFF, 0, 36);
    rst_cyc(1);
    fade_run("restart", 8'hFF, 0, 66);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
